// File: rtl/n64_pi_initiator.sv
// N64-side PI bus master: ALEH/ALEL address phases, then READ/WRITE strobed
// halfword bursts on the multiplexed 16-bit AD bus, fed by valid/ready streams.
module n64_pi_initiator #(
   parameter int unsigned T_ALE         = 4,
   parameter int unsigned T_STROBE_LOW  = 6,
   parameter int unsigned T_STROBE_HIGH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_address,
   input  logic [7:0]  cmd_length,
   input  logic [15:0] wdata,
   input  logic        wdata_valid,
   output logic        wdata_ready,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   output logic        busy,
   output logic        n64_pi_alel,
   output logic        n64_pi_aleh,
   output logic        n64_pi_read,
   output logic        n64_pi_write,
   output logic [15:0] n64_pi_ad_out,
   output logic        n64_pi_ad_oe,
   input  logic [15:0] n64_pi_ad_in
);

   localparam int unsigned T_MAX0 = (T_ALE > T_STROBE_LOW) ? T_ALE : T_STROBE_LOW;
   localparam int unsigned T_MAX  = (T_MAX0 > T_STROBE_HIGH) ? T_MAX0 : T_STROBE_HIGH;
   localparam int unsigned CW     = $clog2(T_MAX + 1);

   localparam logic [CW-1:0] ALE_LAST  = CW'(T_ALE - 1);
   localparam logic [CW-1:0] LOW_LAST  = CW'(T_STROBE_LOW - 1);
   localparam logic [CW-1:0] HIGH_LAST = CW'(T_STROBE_HIGH - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR_HI,
      ADDR_LO,
      ADDR_SETTLE,
      WAIT_DATA,
      STROBE_LOW,
      STROBE_HIGH,
      DONE
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [8:0]    hw_cnt, hw_cnt_nx;
   logic [31:0]   addr, addr_nx;
   logic [7:0]    len, len_nx;
   logic          dir_wr, dir_wr_nx;

   logic [15:0]   rdata_nx, ad_out_nx;
   logic          rdata_valid_nx, aleh_nx, alel_nx, read_nx, write_nx;
   logic          ad_oe_nx, busy_nx, cmd_ready_nx;

   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt + 1'b1;
      hw_cnt_nx      = hw_cnt;
      addr_nx        = addr;
      len_nx         = len;
      dir_wr_nx      = dir_wr;
      rdata_nx       = rdata;
      rdata_valid_nx = 1'b0;
      ad_out_nx      = n64_pi_ad_out;
      wdata_ready    = 1'b0;

      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (cmd_valid && cmd_ready) begin
               addr_nx   = {cmd_address[31:1], 1'b0};
               len_nx    = cmd_length;
               dir_wr_nx = cmd_write;
               hw_cnt_nx = '0;
               ad_out_nx = cmd_address[31:16];
               state_nx  = ADDR_HI;
            end
         end
         ADDR_HI: begin
            if (cnt == ALE_LAST) begin
               cnt_nx    = '0;
               ad_out_nx = addr[15:0];
               state_nx  = ADDR_LO;
            end
         end
         ADDR_LO: begin
            if (cnt == ALE_LAST) begin
               cnt_nx   = '0;
               state_nx = ADDR_SETTLE;
            end
         end
         ADDR_SETTLE: begin
            if (cnt == ALE_LAST) begin
               cnt_nx   = '0;
               state_nx = dir_wr ? WAIT_DATA : STROBE_LOW;
            end
         end
         WAIT_DATA: begin
            cnt_nx      = '0;
            wdata_ready = wdata_valid;
            if (wdata_valid) begin
               ad_out_nx = wdata;
               state_nx  = STROBE_LOW;
            end
         end
         STROBE_LOW: begin
            if (cnt == LOW_LAST) begin
               cnt_nx   = '0;
               state_nx = STROBE_HIGH;
               if (!dir_wr) begin
                  rdata_nx       = n64_pi_ad_in;
                  rdata_valid_nx = 1'b1;
               end
            end
         end
         STROBE_HIGH: begin
            if (cnt == HIGH_LAST) begin
               cnt_nx = '0;
               if (hw_cnt == {1'b0, len}) begin
                  state_nx = DONE;
               end else begin
                  hw_cnt_nx = hw_cnt + 9'd1;
                  state_nx  = dir_wr ? WAIT_DATA : STROBE_LOW;
               end
            end
         end
         DONE: begin
            cnt_nx    = '0;
            ad_out_nx = '0;
            state_nx  = IDLE;
         end
         default: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase

      // PI pins are registered images of the state being entered. Reads
      // release AD for the whole settle phase so the bus is turned around
      // T_ALE cycles before READ can fall.
      aleh_nx      = (state_nx == ADDR_HI);
      alel_nx      = (state_nx == ADDR_HI) || (state_nx == ADDR_LO);
      read_nx      = !((state_nx == STROBE_LOW) && !dir_wr_nx);
      write_nx     = !((state_nx == STROBE_LOW) && dir_wr_nx);
      ad_oe_nx     = alel_nx ||
                     (dir_wr_nx && ((state_nx == ADDR_SETTLE) || (state_nx == WAIT_DATA) ||
                                    (state_nx == STROBE_LOW)  || (state_nx == STROBE_HIGH)));
      busy_nx      = (state_nx != IDLE) && (state_nx != DONE);
      cmd_ready_nx = (state_nx == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         cnt           <= '0;
         hw_cnt        <= '0;
         addr          <= '0;
         len           <= '0;
         dir_wr        <= 1'b0;
         rdata         <= '0;
         rdata_valid   <= 1'b0;
         n64_pi_ad_out <= '0;
         n64_pi_aleh   <= 1'b0;
         n64_pi_alel   <= 1'b0;
         n64_pi_read   <= 1'b1;
         n64_pi_write  <= 1'b1;
         n64_pi_ad_oe  <= 1'b0;
         busy          <= 1'b0;
         cmd_ready     <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         hw_cnt        <= hw_cnt_nx;
         addr          <= addr_nx;
         len           <= len_nx;
         dir_wr        <= dir_wr_nx;
         rdata         <= rdata_nx;
         rdata_valid   <= rdata_valid_nx;
         n64_pi_ad_out <= ad_out_nx;
         n64_pi_aleh   <= aleh_nx;
         n64_pi_alel   <= alel_nx;
         n64_pi_read   <= read_nx;
         n64_pi_write  <= write_nx;
         n64_pi_ad_oe  <= ad_oe_nx;
         busy          <= busy_nx;
         cmd_ready     <= cmd_ready_nx;
      end
   end

endmodule
